ntt_job_arbiter: RTL and testbench

- Shares one ntt_forward core between NUM_REQ requesters. Each requester submits a job as a stream of N coefficients.
- The block grants requesters round-robin and performs four steps per job:
  - streams the coefficients into the core load port;
  - pulses start;
  - waits for done;
  - streams the N results out on a single tagged valid/ready output.
- Sits between the client DMA/stream fabric and the NTT core.
- Exactly one job is in flight at a time.

---
 rtl/ntt_job_arbiter.sv | 110 +++++++++++
 tb/tb_ntt_job_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_job_arbiter.sv
// ntt_job_arbiter: round-robin sharing of one NTT core between NUM_REQ coefficient streams
// Ports:
//   s_valid/s_ready/s_data : per-requester input beats, requester r at s_data[r*WIDTH +: WIDTH]
//   m_valid/m_ready/m_data/m_id/m_last : tagged result stream, N beats per job
//   core_load_* / core_start / core_done / core_busy / core_read_* : NTT core side
//   arb_busy : job in flight, grant_id : requester currently granted
module ntt_job_arbiter #(
  parameter int N          = 256,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 2,
  parameter int ID_WIDTH   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         s_valid,
  output logic [NUM_REQ-1:0]         s_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [ID_WIDTH-1:0]        m_id,
  output logic                       m_last,
  output logic                       core_load_coeff,
  output logic [ADDR_WIDTH-1:0]      core_load_addr,
  output logic [WIDTH-1:0]           core_load_data,
  output logic                       core_start,
  input  logic                       core_done,
  input  logic                       core_busy,
  output logic [ADDR_WIDTH-1:0]      core_read_addr,
  input  logic [WIDTH-1:0]           core_read_data,
  output logic                       arb_busy,
  output logic [ID_WIDTH-1:0]        grant_id
);
  typedef enum logic [2:0] {IDLE, LOAD, START, COMPUTE, UNLOAD} state_t;
  state_t                state_q;
  logic [ID_WIDTH-1:0]   rr_ptr_q, grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] in_cnt_q, out_idx_q;
  logic                  primed_q, in_hs, out_hs;
  logic [NUM_REQ-1:0]    rot;
  logic [ID_WIDTH:0]     sum;
  logic [WIDTH-1:0]      s_word [NUM_REQ];
  logic                  unused_busy;
  assign unused_busy = core_busy;
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_word
    assign s_word[r] = s_data[r*WIDTH +: WIDTH];
  end
  // rot[i] is the request that sits i places above rr_ptr; the lowest set offset wins
  always_comb begin
    grant_d = '0;
    sum = '0;
    rot = NUM_REQ'({s_valid, s_valid} >> rr_ptr_q);
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(i);
      if (rot[i]) grant_d = ID_WIDTH'(sum >= (ID_WIDTH+1)'(NUM_REQ) ? sum - (ID_WIDTH+1)'(NUM_REQ) : sum);
    end
  end
  assign s_ready         = (state_q == LOAD) ? NUM_REQ'(1) << grant_q : '0;
  assign in_hs           = (state_q == LOAD) & s_valid[grant_q];
  assign core_load_coeff = in_hs;
  assign core_load_addr  = in_cnt_q;
  assign core_load_data  = s_word[grant_q];
  assign core_start      = state_q == START;
  assign m_valid         = (state_q == UNLOAD) & primed_q;
  assign out_hs          = m_valid & m_ready;
  assign m_last          = m_valid & (out_idx_q == ADDR_WIDTH'(N - 1));
  assign m_data          = core_read_data;
  assign m_id            = grant_q;
  // look one address ahead on a handshake so the next beat arrives after the core's read latency
  assign core_read_addr  = out_idx_q + ADDR_WIDTH'(out_hs);
  assign arb_busy        = state_q != IDLE;
  assign grant_id        = grant_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      in_cnt_q  <= '0;
      out_idx_q <= '0;
      primed_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|s_valid) begin
          grant_q  <= grant_d;
          in_cnt_q <= '0;
          state_q  <= LOAD;
        end
        LOAD: if (in_hs) begin
          in_cnt_q <= in_cnt_q + 1'b1;
          if (in_cnt_q == ADDR_WIDTH'(N - 1)) state_q <= START;
        end
        START:   state_q <= COMPUTE;
        COMPUTE: if (core_done) state_q <= UNLOAD;
        UNLOAD: begin
          primed_q <= 1'b1;
          if (out_hs) begin
            out_idx_q <= out_idx_q + 1'b1;
            if (m_last) begin
              state_q   <= IDLE;
              out_idx_q <= '0;
              primed_q  <= 1'b0;
              rr_ptr_q  <= (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_job_arbiter.sv
// tb_ntt_job_arbiter: directed job vectors against a behavioural core stub
module tb_ntt_job_arbiter;
  localparam int N = 256, W = 32, AW = 8, NR = 2, IW = 1, LAT = 6;
  logic clk = 0, rst_n = 0;
  logic [NR-1:0] s_valid = '0, s_ready;
  logic [NR*W-1:0] s_data = '0;
  logic m_valid, m_ready = 0, m_last;
  logic [W-1:0] m_data;
  logic [IW-1:0] m_id, grant_id;
  logic core_load_coeff, core_start, core_done, core_busy, arb_busy;
  logic [AW-1:0] core_load_addr, core_read_addr;
  logic [W-1:0] core_load_data, core_read_data;
  always #5 clk = ~clk;

  ntt_job_arbiter #(.N(N), .WIDTH(W), .ADDR_WIDTH(AW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id), .m_last(m_last),
    .core_load_coeff(core_load_coeff), .core_load_addr(core_load_addr), .core_load_data(core_load_data),
    .core_start(core_start), .core_done(core_done), .core_busy(core_busy),
    .core_read_addr(core_read_addr), .core_read_data(core_read_data),
    .arb_busy(arb_busy), .grant_id(grant_id));

  // core stub: result[k] = a[0] + k*a[k]; a delta at index 0 gives all ones like a real NTT
  logic [W-1:0] cmem [N];
  logic [W-1:0] cres [N];
  int cd = 0;
  logic done_p = 0, spur_done = 0;
  assign core_done = done_p | spur_done;
  assign core_busy = cd > 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd <= 0;
      done_p <= 0;
    end else begin
      done_p <= 0;
      if (core_load_coeff) cmem[core_load_addr] <= core_load_data;
      core_read_data <= cres[core_read_addr];
      if (core_start) cd <= LAT;
      else if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          done_p <= 1;
          for (int k = 0; k < N; k++) cres[k] <= cmem[0] + W'(k) * cmem[k];
        end
      end
    end
  end

  typedef struct {logic [W-1:0] d; logic [IW-1:0] id; logic last;} beat_t;
  typedef struct {bit rst; bit delta; int j0; int j1; int vp; int rp; bit spur; int ng; logic [3:0] g;} vec_t;
  beat_t expq[$];
  logic [IW-1:0] gexp[$];
  logic [W-1:0] src [NR][N];
  int sidx[NR], jleft[NR], jnum[NR];
  int checks = 0, errors = 0, cyc = 0, rcv = 0, ld_cnt = 0, last_ld = -10;
  int vpat = 0, rpat = 0;
  bit spur_en = 0, spur_used = 0, prev_spur = 0;
  logic prev_busy = 0, prev_start = 0, prev_mv = 0, prev_mr = 0, prev_ml = 0;
  logic [W-1:0] prev_md = '0;
  logic [IW-1:0] prev_id = '0;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic gen_src(input int r, input bit delta);
    for (int i = 0; i < N; i++)
      src[r][i] = delta ? W'(i == 0) : W'((r + 1) * 1000 + jnum[r] * 37 + i * i);
  endtask

  task automatic step();
    beat_t e;
    @(negedge clk);
    cyc++;
    for (int r = 0; r < NR; r++) begin
      s_valid[r] = (jleft[r] > 0) && (vpat == 0 || cyc % 2 == 0);
      s_data[r*W +: W] = src[r][sidx[r]];
    end
    m_ready = (rpat == 0) ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
    spur_done = 0;
    if (spur_en && !spur_used && s_ready != 0 && ld_cnt == 10) begin
      spur_done = 1;
      spur_used = 1;
    end
    #1;
    chk("s_ready_only_granted", s_ready & ~(NR'(1) << grant_id), 0);
    if (arb_busy && !prev_busy) begin
      if (gexp.size() == 0) chk("unexpected_grant", 1, 0);
      else chk("grant_order", grant_id, gexp.pop_front());
    end
    if (prev_spur) chk("spur_done_stays_load", s_ready != 0, 1);
    if (prev_mv && !prev_mr) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_md);
      chk("stall_id", m_id, prev_id);
      chk("stall_last", m_last, prev_ml);
    end
    if (m_valid) chk("m_valid_while_busy", arb_busy, 1);
    if (core_load_coeff) begin
      chk("load_addr", core_load_addr, ld_cnt);
      chk("load_data", core_load_data, src[grant_id][ld_cnt % N]);
      ld_cnt++;
      last_ld = cyc;
    end
    if (core_start) begin
      chk("start_after_last_load", cyc - last_ld, 1);
      chk("loads_per_job", ld_cnt, N);
      chk("start_single_cycle", prev_start, 0);
      ld_cnt = 0;
    end
    for (int r = 0; r < NR; r++)
      if (s_valid[r] && s_ready[r]) begin
        sidx[r]++;
        if (sidx[r] == N) begin
          for (int k = 0; k < N; k++) expq.push_back('{src[r][0] + W'(k) * src[r][k], IW'(r), k == N - 1});
          sidx[r] = 0;
          jleft[r]--;
          jnum[r]++;
          gen_src(r, 0);
        end
      end
    if (m_valid && m_ready) begin
      if (expq.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = expq.pop_front();
        chk("m_data", m_data, e.d);
        chk("m_id", m_id, e.id);
        chk("m_last", m_last, e.last);
      end
      rcv++;
    end
    prev_spur = spur_done;
    prev_busy = arb_busy;
    prev_start = core_start;
    prev_mv = m_valid;
    prev_mr = m_ready;
    prev_md = m_data;
    prev_id = m_id;
    prev_ml = m_last;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    s_valid = '0;
    m_ready = 0;
    spur_done = 0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_load_coeff", core_load_coeff, 0);
    chk("rst_load_addr", core_load_addr, 0);
    chk("rst_start", core_start, 0);
    chk("rst_arb_busy", arb_busy, 0);
    chk("rst_read_addr", core_read_addr, 0);
    chk("rst_grant_id", grant_id, 0);
    expq.delete();
    gexp.delete();
    for (int r = 0; r < NR; r++) begin
      sidx[r] = 0;
      jleft[r] = 0;
    end
    ld_cnt = 0;
    last_ld = -10;
    {prev_spur, prev_busy, prev_start, prev_mv, prev_mr, prev_ml} = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_vec(input vec_t v, input int stop);
    int total, budget;
    if (v.rst) do_reset();
    vpat = v.vp;
    rpat = v.rp;
    spur_en = v.spur;
    spur_used = 0;
    jleft[0] = v.j0;
    jleft[1] = v.j1;
    for (int r = 0; r < NR; r++) gen_src(r, v.delta && r == 0);
    for (int i = 0; i < v.ng; i++) gexp.push_back(IW'(v.g[i]));
    total = (stop >= 0) ? stop : (v.j0 + v.j1) * N;
    rcv = 0;
    budget = 0;
    while (rcv < total && budget < 20000) begin
      step();
      budget++;
    end
    if (rcv < total) begin
      checks++;
      errors++;
      $display("FAIL timeout: received %0d beats, required %0d", rcv, total);
    end
    if (stop < 0) begin
      step();
      chk("idle_after_job", arb_busy, 0);
      chk("grants_all_seen", gexp.size(), 0);
      chk("results_all_seen", expq.size(), 0);
    end
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < NR; r++) begin
      sidx[r] = 0;
      jleft[r] = 0;
      jnum[r] = 0;
    end
    // single delta job; both requesters streaming from reset; backpressure; input gaps with a
    // stray done (only requester 0 valid although it was served last); requester 1 alone with both
    vecs[0] = '{rst: 1, delta: 1, j0: 1, j1: 0, vp: 0, rp: 0, spur: 0, ng: 1, g: 4'b0000};
    vecs[1] = '{rst: 1, delta: 0, j0: 2, j1: 2, vp: 0, rp: 0, spur: 0, ng: 4, g: 4'b1010};
    vecs[2] = '{rst: 0, delta: 0, j0: 1, j1: 0, vp: 0, rp: 1, spur: 0, ng: 1, g: 4'b0000};
    vecs[3] = '{rst: 0, delta: 0, j0: 1, j1: 0, vp: 1, rp: 0, spur: 1, ng: 1, g: 4'b0000};
    vecs[4] = '{rst: 0, delta: 0, j0: 0, j1: 1, vp: 1, rp: 1, spur: 0, ng: 1, g: 4'b0001};
    for (int i = 0; i < 5; i++) run_vec(vecs[i], -1);
    // requester 0 finishes (rr_ptr -> 1), requester 1 is cut off by reset after beat 100
    run_vec('{rst: 0, delta: 0, j0: 1, j1: 0, vp: 0, rp: 0, spur: 0, ng: 1, g: 4'b0000}, -1);
    run_vec('{rst: 0, delta: 0, j0: 0, j1: 1, vp: 0, rp: 0, spur: 0, ng: 1, g: 4'b0001}, 101);
    do_reset();
    // reset returns rr_ptr to 0, so requester 0 wins when both ask
    run_vec('{rst: 0, delta: 0, j0: 1, j1: 1, vp: 0, rp: 0, spur: 0, ng: 2, g: 4'b0010}, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
